sar_search_ctrl: RTL



---
 rtl/sar_search_ctrl_pkg.sv | 17 +
 rtl/sar_search_ctrl_if.sv | 29 ++
 rtl/sar_search_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - shared types and helpers for the SAR search controller
package sar_search_ctrl_pkg;

    localparam int SAR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TEST   = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    // A trustworthy comparator asserts exactly one of its three flags.
    function automatic logic flags_onehot(input logic gt, input logic lt, input logic eq);
        return (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// rtl/sar_search_ctrl_if.sv - controller <-> comparator/host signal bundle
interface sar_search_ctrl_if #(
    parameter int WIDTH = sar_search_ctrl_pkg::SAR_WIDTH
) ();

    logic             start;
    logic             cmpGreater;
    logic             cmpLess;
    logic             cmpEqual;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    // The search controller.
    modport master (
        input  start, cmpGreater, cmpLess, cmpEqual,
        output trial, busy, done, result, found, err
    );

    // Host plus comparator side.
    modport slave (
        output start, cmpGreater, cmpLess, cmpEqual,
        input  trial, busy, done, result, found, err
    );

endinterface

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - MSB-first binary search against an external comparator
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic              clk,
    input  logic              rstN,
    sar_search_ctrl_if.master bus
);

    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             flags_ok;

    assign flags_ok = flags_onehot(bus.cmpGreater, bus.cmpLess, bus.cmpEqual);

    // Next-state and datapath: one comparison per cycle, early exit on equality.
    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        found_d   = found_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                // done_q marks the first idle cycle; a start seen there is deferred.
                if (bus.start && !done_q) begin
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    bit_idx_d          = IDX_MSB;
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                    busy_d             = 1'b1;
                    state_d            = ST_TEST;
                end
            end
            ST_TEST: begin
                if (!flags_ok) begin
                    result_d = trial_q;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (bus.cmpEqual) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    // Trial too big clears the tentative bit; too small keeps it.
                    trial_d[bit_idx_q] = bus.cmpLess;
                    if (bit_idx_q != '0) begin
                        trial_d[bit_idx_q - 1'b1] = 1'b1;
                        bit_idx_d                 = bit_idx_q - 1'b1;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                result_d = trial_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                if (!flags_ok) begin
                    err_d = 1'b1;
                end else begin
                    // Greater/less here means the target moved during the search.
                    found_d = bus.cmpEqual;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any search silently.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= ST_IDLE;
            trial_q   <= '0;
            result_q  <= '0;
            bit_idx_q <= IDX_MSB;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            trial_q   <= trial_d;
            result_q  <= result_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            err_q     <= err_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;

endmodule
